// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end between the execute stage and a
// word-addressed data RAM with 4-bit byte write enable and one-cycle read.
// One byte/half/word request is handled at a time. Misaligned and
// illegal-size requests are answered with an error and never reach the RAM.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   req_valid/req_ready             request handshake (ready = idle)
//   req_we, req_size, req_sign      store/load, size (00 B, 01 H, 10 W), load extension
//   req_addr, req_wdata             byte address, right-aligned store data
//   resp_valid, resp_err, resp_rdata  one-cycle completion pulse, error flag, load data
//   ram_wea, ram_addra, ram_dina    RAM write enables, word address, write data
//   ram_douta                       RAM read data
//   ld_cnt, st_cnt, err_cnt         completed loads / stores / errors
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [31:0]       ram_dina,
  input  logic [31:0]       ram_douta,
  output logic [CNT_W-1:0]  ld_cnt,
  output logic [CNT_W-1:0]  st_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ST   = 3'd1;
  localparam logic [2:0] S_LDA  = 3'd2;
  localparam logic [2:0] S_LDD  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic              ready_q, ready_d;
  logic              rvld_q, rvld_d;
  logic              rerr_q, rerr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [3:0]        wea_q, wea_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [31:0]       dina_q, dina_d;
  logic [CNT_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0]  st_cnt_q, st_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  // latched load attributes, needed two cycles after accept
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;

  logic        req_bad;
  logic [3:0]  lane_wea;
  logic [31:0] lane_dina;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  always_comb begin
    req_bad = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // store lane steering (little-endian)
  always_comb begin
    case (req_size)
      2'b00: begin
        lane_wea  = 4'b0001 << req_addr[1:0];
        lane_dina = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_wea  = 4'b0011 << req_addr[1:0];
        lane_dina = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_wea  = 4'b1111;
        lane_dina = req_wdata;
      end
    endcase
  end

  // load extraction: shift the addressed lane down to bit 0, then extend
  always_comb begin
    rd_shift = ram_douta >> {off_q, 3'b000};
    case (size_q)
      2'b00:   rd_ext = sign_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                               : {24'h0, rd_shift[7:0]};
      2'b01:   rd_ext = sign_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                               : {16'h0, rd_shift[15:0]};
      default: rd_ext = ram_douta;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    rvld_d    = 1'b0;
    rerr_d    = 1'b0;
    rdata_d   = rdata_q;
    wea_d     = 4'b0000;
    addra_d   = addra_q;
    dina_d    = dina_q;
    ld_cnt_d  = ld_cnt_q;
    st_cnt_d  = st_cnt_q;
    err_cnt_d = err_cnt_q;
    size_d    = size_q;
    sign_d    = sign_q;
    off_d     = off_q;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (req_valid) begin
          ready_d = 1'b0;
          size_d  = req_size;
          sign_d  = req_sign;
          off_d   = req_addr[1:0];
          if (req_bad) begin
            // answered straight away; RAM is left alone
            state_d = S_RESP;
            rvld_d  = 1'b1;
            rerr_d  = 1'b1;
            rdata_d = 32'h0;
            if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + CNT_ONE;
          end else begin
            addra_d = {2'b00, req_addr[ADDR_W-1:2]};
            if (req_we) begin
              state_d = S_ST;
              wea_d   = lane_wea;
              dina_d  = lane_dina;
            end else begin
              state_d = S_LDA;
            end
          end
        end
      end
      S_ST: begin
        state_d  = S_RESP;
        rvld_d   = 1'b1;
        rdata_d  = 32'h0;
        st_cnt_d = st_cnt_q + CNT_ONE;
      end
      S_LDA: state_d = S_LDD;
      S_LDD: begin
        state_d  = S_RESP;
        rvld_d   = 1'b1;
        rdata_d  = rd_ext;
        ld_cnt_d = ld_cnt_q + CNT_ONE;
      end
      S_RESP: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        rdata_d = 32'h0;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // async reset clears wea immediately, cutting off any in-flight write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b1;
      rvld_q    <= 1'b0;
      rerr_q    <= 1'b0;
      rdata_q   <= 32'h0;
      wea_q     <= 4'b0000;
      addra_q   <= '0;
      dina_q    <= 32'h0;
      ld_cnt_q  <= '0;
      st_cnt_q  <= '0;
      err_cnt_q <= '0;
      size_q    <= 2'b00;
      sign_q    <= 1'b0;
      off_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      rvld_q    <= rvld_d;
      rerr_q    <= rerr_d;
      rdata_q   <= rdata_d;
      wea_q     <= wea_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      ld_cnt_q  <= ld_cnt_d;
      st_cnt_q  <= st_cnt_d;
      err_cnt_q <= err_cnt_d;
      size_q    <= size_d;
      sign_q    <= sign_d;
      off_q     <= off_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = rvld_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = rdata_q;
  assign ram_wea    = wea_q;
  assign ram_addra  = addra_q;
  assign ram_dina   = dina_q;
  assign ld_cnt     = ld_cnt_q;
  assign st_cnt     = st_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule
